// File: rtl/fifo_arb_pkg.sv
// Shared types and round-robin index helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} arb_state_t;

    localparam int unsigned STALL_W = 16;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/fifo_wr_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of vec at or above base, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] base,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;

    // Rotate a doubled copy so the scan always starts at bit 0.
    always_comb begin
        rot = N'({vec, vec} >> base);
        off = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
        end
        idx    = IW'(rr_wrap(32'(base) + 32'(off), N));
        any    = |vec;
        onehot = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned IW       = $clog2(NUM_REQ),
    localparam int unsigned BW       = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     full,
    output logic                     wr_en,
    output logic [WIDTH-1:0]         data_in,
    output logic [IW-1:0]            grant_id,
    output logic                     busy,
    output logic [STALL_W-1:0]       stall_cnt
);

    arb_state_t        st;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     owner;
    logic [BW-1:0]     burst_cnt;

    logic [IW-1:0]      owner_inc;
    logic [IW-1:0]      base;
    logic [IW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_any;
    logic               hold_own;
    logic [IW-1:0]      sel;
    logic               sel_vld;
    logic               xfer;
    logic               last_beat;

    assign owner_inc = IW'(rr_next(32'(owner), NUM_REQ));
    assign hold_own  = (st == HOLD) && req_valid[owner];
    assign base      = (st == IDLE) ? rr_ptr : owner_inc;
    assign last_beat = (burst_cnt == BW'(MAX_BURST - 1));
    assign busy      = (st == HOLD);

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .vec    (req_valid),
        .base   (base),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Zero-latency grant path; rst_n gating keeps the write port quiet during reset.
    always_comb begin
        sel       = hold_own ? owner : pick_idx;
        sel_vld   = rst_n && (hold_own || pick_any);
        xfer      = sel_vld && !full;
        wr_en     = xfer;
        req_ready = '0;
        if (xfer) req_ready = hold_own ? (NUM_REQ'(1) << owner) : pick_onehot;
        data_in   = sel_vld ? req_data[32'(sel)*WIDTH +: WIDTH] : '0;
        grant_id  = sel_vld ? sel : owner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (xfer) begin
                if (st == IDLE || sel != owner) begin
                    owner     <= sel;
                    burst_cnt <= BW'(1);
                    if (MAX_BURST == 1) begin
                        st     <= IDLE;
                        rr_ptr <= IW'(rr_next(32'(sel), NUM_REQ));
                    end else begin
                        st <= HOLD;
                    end
                end else if (last_beat) begin
                    st        <= IDLE;
                    rr_ptr    <= owner_inc;
                    burst_cnt <= '0;
                end else begin
                    burst_cnt <= burst_cnt + BW'(1);
                end
            end else if (!full && st == HOLD && !pick_any) begin
                st        <= IDLE;
                rr_ptr    <= owner_inc;
                burst_cnt <= '0;
            end
            if (full && (|req_valid) && stall_cnt != '1)
                stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Randomised and directed bench for fifo_wr_rr_arbiter with a per-producer scoreboard.
module tb_fifo_wr_rr_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic           full = 1'b0;
    logic [N-1:0]   req_ready;
    logic           wr_en;
    logic [W-1:0]   data_in;
    logic [1:0]     grant_id;
    logic           busy;
    logic [15:0]    stall_cnt;

    fifo_wr_rr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .grant_id  (grant_id),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int cyc = 0;
    int seq = 0;
    bit rnd_mode = 1'b0;

    logic [W-1:0] src_q[N][$];
    logic [W-1:0] exp_q[N][$];
    int           gnt_log[$];
    int           wcyc[$];

    // Reference model: last winner, beats in the current burst, fresh-after-reset flag.
    int m_last = 0;
    int m_cnt = 0;
    bit m_fresh = 1'b1;
    int m_stall = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic int exp_sel(input logic [N-1:0] vld);
        int b;
        if (m_cnt > 0 && vld[m_last]) return m_last;
        b = m_fresh ? 0 : (m_last + 1) % N;
        for (int k = 0; k < N; k++) begin
            if (vld[(b + k) % N]) return (b + k) % N;
        end
        return -1;
    endfunction

    // Monitor: compares every output against the model and pops the scoreboard on each write.
    always @(negedge clk) begin
        int  s;
        bit  xf;
        cyc++;
        if (!rst_n) begin
            chk("rst_wr_en", 32'(wr_en), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_data_in", 32'(data_in), 32'd0);
            chk("rst_grant_id", 32'(grant_id), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
            m_last  = 0;
            m_cnt   = 0;
            m_fresh = 1'b1;
            m_stall = 0;
        end else begin
            s  = exp_sel(req_valid);
            xf = (s >= 0) && !full;
            chk("wr_en", 32'(wr_en), 32'(xf));
            chk("req_ready", 32'(req_ready), xf ? (32'd1 << s) : 32'd0);
            chk("grant_id", 32'(grant_id), (s >= 0) ? 32'(s) : 32'(m_last));
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            if (s >= 0) chk("data_in", 32'(data_in), 32'(req_data[s*W +: W]));
            else        chk("data_in_idle", 32'(data_in), 32'd0);
            if (wr_en) begin
                wr_cnt++;
                gnt_log.push_back(int'(grant_id));
                wcyc.push_back(cyc);
            end
            if (xf) begin
                if (exp_q[s].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_dup: write from producer %0d with no pending beat", s);
                end else begin
                    chk("sb_data", 32'(data_in), 32'(exp_q[s].pop_front()));
                end
                if (s == m_last && m_cnt > 0) m_cnt++;
                else m_cnt = 1;
                if (m_cnt == MB) m_cnt = 0;
                m_last  = s;
                m_fresh = 1'b0;
            end else if (!full && req_valid == '0) begin
                m_cnt = 0;
            end
            if (full && (|req_valid) && m_stall < 65535) m_stall++;
        end
    end

    // One clock of producer behaviour: retire accepted beats, present queued ones.
    task automatic cycle();
        logic [N-1:0] acc;
        logic [W-1:0] d;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && acc[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && src_q[i].size() > 0 && !(rnd_mode && $urandom_range(0, 1) == 0)) begin
                d = src_q[i].pop_front();
                req_data[i*W +: W] = d;
                req_valid[i] = 1'b1;
                exp_q[i].push_back(d);
            end
        end
    endtask

    task automatic load(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            src_q[p].push_back(16'(p << 12) | 16'(seq & 12'hFFF));
            seq++;
        end
    endtask

    task automatic wait_wr(input int target, input string nm);
        int b = 0;
        while (wr_cnt < target && b < 300) begin
            cycle();
            b++;
        end
        if (wr_cnt < target) chk({nm, "_timeout"}, 32'(wr_cnt), 32'(target));
    endtask

    task automatic drain(input string nm);
        int b = 0;
        int pend;
        do begin
            pend = 0;
            for (int i = 0; i < N; i++) pend += src_q[i].size();
            if (pend == 0 && req_valid == '0) break;
            cycle();
            b++;
        end while (b < 3000);
        pend = 0;
        for (int i = 0; i < N; i++) pend += exp_q[i].size() + src_q[i].size();
        chk({nm, "_drain_pending"}, 32'(pend), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int gl;
        int base_w;

        // Reset with all producers presenting, then constant 4'hF arbitration.
        for (int i = 0; i < N; i++) load(i, 8);
        cycle();
        cycle();
        chk("t1_wr_en", 32'(wr_en), 32'd0);
        chk("t1_req_ready", 32'(req_ready), 32'd0);
        chk("t1_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("t1_grant_id", 32'(grant_id), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_valid_all", 32'(req_valid), 32'hF);
        rst_n = 1'b1;
        gl = gnt_log.size();
        wait_wr(wr_cnt + 17, "t3");
        for (int k = 0; k < 17; k++)
            if (gnt_log.size() > gl + k) chk($sformatf("t3_grant%0d", k), 32'(gnt_log[gl+k]), 32'((k / 4) % N));
        drain("t3");

        // Single producer streams six beats with no bubble across the burst limit.
        for (int k = 0; k < 6; k++) src_q[2].push_back(16'h2000 + 16'(k));
        base_w = wr_cnt;
        gl = gnt_log.size();
        repeat (7) cycle();
        chk("t2_writes", 32'(wr_cnt - base_w), 32'd6);
        for (int k = 0; k < 6; k++)
            if (gnt_log.size() > gl + k) chk($sformatf("t2_grant%0d", k), 32'(gnt_log[gl+k]), 32'd2);
        if (wcyc.size() >= gl + 6) chk("t2_back_to_back", 32'(wcyc[gl+5] - wcyc[gl]), 32'd5);
        drain("t2");

        // Full stalls an in-progress burst; the burst resumes and then rotates.
        do_reset();
        load(1, 4);
        base_w = wr_cnt;
        gl = gnt_log.size();
        wait_wr(base_w + 2, "t4a");
        full = 1'b1;
        load(2, 2);
        repeat (3) cycle();
        chk("t4_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("t4_no_write", 32'(wr_cnt - base_w), 32'd2);
        full = 1'b0;
        wait_wr(base_w + 5, "t4b");
        if (gnt_log.size() >= gl + 5) begin
            chk("t4_resume0", 32'(gnt_log[gl+2]), 32'd1);
            chk("t4_resume1", 32'(gnt_log[gl+3]), 32'd1);
            chk("t4_next", 32'(gnt_log[gl+4]), 32'd2);
        end
        drain("t4");

        // Owner drops after one beat; another producer is granted with no bubble.
        do_reset();
        load(0, 1);
        load(3, 2);
        gl = gnt_log.size();
        wait_wr(wr_cnt + 2, "t5");
        if (gnt_log.size() >= gl + 2) begin
            chk("t5_first", 32'(gnt_log[gl]), 32'd0);
            chk("t5_second", 32'(gnt_log[gl+1]), 32'd3);
            chk("t5_no_bubble", 32'(wcyc[gl+1] - wcyc[gl]), 32'd1);
        end
        drain("t5");

        // Reset pulse mid-burst silences the port immediately; arbitration restarts at 0.
        do_reset();
        load(2, 6);
        wait_wr(wr_cnt + 2, "t6a");
        rst_n = 1'b0;
        #1;
        chk("t6_async_wr_en", 32'(wr_en), 32'd0);
        chk("t6_async_ready", 32'(req_ready), 32'd0);
        load(0, 4);
        load(1, 4);
        load(3, 4);
        cycle();
        cycle();
        rst_n = 1'b1;
        gl = gnt_log.size();
        wait_wr(wr_cnt + 1, "t6b");
        if (gnt_log.size() > gl) chk("t6_first_grant", 32'(gnt_log[gl]), 32'd0);
        drain("t6");

        // Random traffic with random full; the monitor checks every cycle.
        rnd_mode = 1'b1;
        repeat (600) begin
            if ($urandom_range(0, 2) == 0) load(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 5)));
            full = ($urandom_range(0, 3) == 0);
            cycle();
        end
        full = 1'b0;
        drain("rand");
        rnd_mode = 1'b0;

        // Stall counter saturation.
        do_reset();
        load(0, 1);
        full = 1'b1;
        repeat (70000) cycle();
        chk("stall_saturate", 32'(stall_cnt), 32'h0000FFFF);
        full = 1'b0;
        drain("sat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
